rvfi_commit_checker: RTL and testbench

RVFI_COMMIT_CHECKER -- requirements
Module: rvfi_commit_checker

---
 rtl/rvfi_commit_checker.sv | 163 ++++++++++++++++
 tb/tb_rvfi_commit_checker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_commit_checker.sv
// Checks an RVFI-style retirement stream for order, PC chaining, x0, memory alignment and
// deadlock. The first error is latched and the checker freezes until reset.
module rvfi_commit_checker #(
  parameter int unsigned WATCHDOG_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [63:0] commit_order,
  input  logic [31:0] commit_pc_rdata,
  input  logic [31:0] commit_pc_wdata,
  input  logic [4:0]  commit_rd_addr,
  input  logic [31:0] commit_rd_wdata,
  input  logic [31:0] commit_mem_addr,
  input  logic [3:0]  commit_mem_rmask,
  input  logic [3:0]  commit_mem_wmask,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [63:0] err_order,
  output logic [63:0] commit_count,
  output logic        halted
);

  localparam int unsigned WdW = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WdW-1:0] WdLimit = WdW'(WATCHDOG_CYCLES);

  localparam logic [2:0] CodeNone  = 3'd0;
  localparam logic [2:0] CodeOrder = 3'd1;
  localparam logic [2:0] CodePc    = 3'd2;
  localparam logic [2:0] CodeX0    = 3'd3;
  localparam logic [2:0] CodeMem   = 3'd4;
  localparam logic [2:0] CodeDead  = 3'd5;

  typedef enum logic [1:0] {StIdle, StRun, StHalt, StFail} state_e;

  state_e         state_q, state_d;
  logic           err_q, err_d;
  logic [2:0]     err_code_q, err_code_d;
  logic [63:0]    err_order_q, err_order_d;
  logic [63:0]    count_q, count_d;
  logic           halted_q, halted_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic [63:0]    exp_order_q, exp_order_d;
  logic [31:0]    last_pc_q, last_pc_d;

  logic           x0_bad, mem_bad, order_bad, pc_bad, is_halt;
  logic [2:0]     idle_code, run_code;
  logic [WdW-1:0] wd_inc;
  logic           unused_addr;

  // Only the two low address bits matter for alignment.
  assign unused_addr = ^commit_mem_addr[31:2];

  function automatic logic misaligned(input logic [3:0] mask, input logic [1:0] lsb);
    logic bad;
    bad = 1'b0;
    if (mask == 4'b1111) begin
      bad = (lsb != 2'b00);
    end else if ((mask == 4'b0011) || (mask == 4'b1100)) begin
      bad = lsb[0];
    end
    return bad;
  endfunction

  always_comb begin
    x0_bad    = (commit_rd_addr == 5'd0) && (commit_rd_wdata != 32'd0);
    mem_bad   = ((commit_mem_rmask != 4'd0) && (commit_mem_wmask != 4'd0)) ||
                misaligned(commit_mem_rmask, commit_mem_addr[1:0]) ||
                misaligned(commit_mem_wmask, commit_mem_addr[1:0]);
    order_bad = (commit_order != exp_order_q);
    pc_bad    = (commit_pc_rdata != last_pc_q);
    is_halt   = (commit_pc_wdata == commit_pc_rdata);

    // Lowest code wins when several checks fail together.
    if (x0_bad)       idle_code = CodeX0;
    else if (mem_bad) idle_code = CodeMem;
    else              idle_code = CodeNone;

    if (order_bad)    run_code = CodeOrder;
    else if (pc_bad)  run_code = CodePc;
    else              run_code = idle_code;

    wd_inc = (wd_q == '1) ? wd_q : wd_q + WdW'(1);
  end

  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    err_order_d = err_order_q;
    count_d     = count_q;
    halted_d    = halted_q;
    wd_d        = wd_q;
    exp_order_d = exp_order_q;
    last_pc_d   = last_pc_q;

    case (state_q)
      StIdle, StRun: begin
        if (commit_valid) begin
          logic [2:0] code;
          code = (state_q == StIdle) ? idle_code : run_code;
          wd_d = '0;
          if (code != CodeNone) begin
            state_d     = StFail;
            err_d       = 1'b1;
            err_code_d  = code;
            err_order_d = commit_order;
          end else begin
            count_d     = count_q + 64'd1;
            exp_order_d = commit_order + 64'd1;
            last_pc_d   = commit_pc_wdata;
            if (is_halt) begin
              state_d  = StHalt;
              halted_d = 1'b1;
            end else begin
              state_d = StRun;
            end
          end
        end else if (state_q == StRun) begin
          wd_d = wd_inc;
          if (wd_inc >= WdLimit) begin
            state_d     = StFail;
            err_d       = 1'b1;
            err_code_d  = CodeDead;
            err_order_d = exp_order_q;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      err_q       <= 1'b0;
      err_code_q  <= 3'd0;
      err_order_q <= 64'd0;
      count_q     <= 64'd0;
      halted_q    <= 1'b0;
      wd_q        <= '0;
      exp_order_q <= 64'd0;
      last_pc_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      err_order_q <= err_order_d;
      count_q     <= count_d;
      halted_q    <= halted_d;
      wd_q        <= wd_d;
      exp_order_q <= exp_order_d;
      last_pc_q   <= last_pc_d;
    end
  end

  assign err          = err_q;
  assign err_code     = err_code_q;
  assign err_order    = err_order_q;
  assign commit_count = count_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_rvfi_commit_checker.sv
// Directed bench for rvfi_commit_checker: stimulus pushes expected snapshots tagged with the
// cycle they should appear in; a negedge monitor pops and compares them.
module tb_rvfi_commit_checker;

  localparam logic [31:0] P0 = 32'h6000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        c_valid = 1'b0;
  logic [63:0] c_order = '0;
  logic [31:0] c_pcr = '0, c_pcw = '0;
  logic [4:0]  c_rd = 5'd1;
  logic [31:0] c_rdw = '0, c_addr = '0;
  logic [3:0]  c_rm = '0, c_wm = '0;
  logic        err, halted;
  logic [2:0]  err_code;
  logic [63:0] err_order, commit_count;

  rvfi_commit_checker #(.WATCHDOG_CYCLES(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .commit_valid    (c_valid),
    .commit_order    (c_order),
    .commit_pc_rdata (c_pcr),
    .commit_pc_wdata (c_pcw),
    .commit_rd_addr  (c_rd),
    .commit_rd_wdata (c_rdw),
    .commit_mem_addr (c_addr),
    .commit_mem_rmask(c_rm),
    .commit_mem_wmask(c_wm),
    .err             (err),
    .err_code        (err_code),
    .err_order       (err_order),
    .commit_count    (commit_count),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    string       name;
    logic        err;
    logic [2:0]  code;
    logic [63:0] order;
    logic [63:0] count;
    logic        halted;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input string field, input logic [63:0] act,
                     input logic [63:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, expected %0h", name, field, act, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        chk(e.name, "missed_cycle", 64'(cyc), 64'(e.cyc));
      end else begin
        chk(e.name, "err", 64'(err), 64'(e.err));
        chk(e.name, "err_code", 64'(err_code), 64'(e.code));
        chk(e.name, "err_order", err_order, e.order);
        chk(e.name, "commit_count", commit_count, e.count);
        chk(e.name, "halted", 64'(halted), 64'(e.halted));
      end
    end
  end

  task automatic push_at(input int unsigned at, input string name, input logic e_err,
                         input logic [2:0] code, input logic [63:0] order,
                         input logic [63:0] count, input logic e_halted);
    exp_t e;
    e.cyc = at; e.name = name; e.err = e_err; e.code = code;
    e.order = order; e.count = count; e.halted = e_halted;
    sb.push_back(e);
  endtask

  // Expectation for the cycle after the one just driven.
  task automatic push_exp(input string name, input logic e_err, input logic [2:0] code,
                          input logic [63:0] order, input logic [63:0] count,
                          input logic e_halted);
    push_at(cyc + 1, name, e_err, code, order, count, e_halted);
  endtask

  task automatic drive(input logic v, input logic [63:0] o, input logic [31:0] pr,
                       input logic [31:0] pw, input logic [4:0] rd, input logic [31:0] rdw,
                       input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm);
    @(posedge clk);
    #1;
    c_valid = v; c_order = o; c_pcr = pr; c_pcw = pw;
    c_rd = rd; c_rdw = rdw; c_addr = a; c_rm = rm; c_wm = wm;
  endtask

  task automatic commit(input logic [63:0] o, input logic [31:0] pr, input logic [31:0] pw);
    drive(1'b1, o, pr, pw, 5'd1, 32'd0, 32'd0, 4'd0, 4'd0);
  endtask

  task automatic idle();
    drive(1'b0, 64'd0, 32'd0, 32'd0, 5'd1, 32'd0, 32'd0, 4'd0, 4'd0);
  endtask

  // Reset lands mid-cycle; the zeros are checked on the same cycle's falling edge.
  task automatic do_reset();
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    push_at(cyc, "async_reset", 1'b0, 3'd0, 64'd0, 64'd0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    do_reset();
    commit(0, P0, P0 + 4);       push_exp("seq0", 0, 0, 0, 1, 0);
    commit(1, P0 + 4, P0 + 8);   push_exp("seq1", 0, 0, 0, 2, 0);
    commit(2, P0 + 8, P0 + 12);  push_exp("seq2", 0, 0, 0, 3, 0);
    commit(3, P0 + 12, P0 + 16); push_exp("seq3", 0, 0, 0, 4, 0);

    do_reset();
    commit(0, P0, P0 + 4);
    commit(1, P0 + 4, P0 + 8);   push_exp("gap_pre", 0, 0, 0, 2, 0);
    commit(3, P0 + 8, P0 + 12);  push_exp("gap", 1, 1, 3, 2, 0);
    commit(4, P0 + 12, P0 + 16); push_exp("gap_frozen", 1, 1, 3, 2, 0);
    for (int i = 0; i < 10; i++) idle();
    push_exp("gap_idle", 1, 1, 3, 2, 0);

    do_reset();
    commit(5, P0 + 32'h40, P0 + 32'h44); push_exp("reseed0", 0, 0, 0, 1, 0);
    commit(6, P0 + 32'h44, P0 + 32'h48); push_exp("reseed1", 0, 0, 0, 2, 0);

    do_reset();
    commit(0, P0, P0 + 8);       push_exp("pc_pre", 0, 0, 0, 1, 0);
    commit(1, P0 + 12, P0 + 16); push_exp("pc", 1, 2, 1, 1, 0);

    do_reset();
    commit(0, P0, P0 + 8);
    drive(1, 1, P0 + 12, P0 + 16, 5'd0, 32'd5, 32'd0, 4'd0, 4'd0);
    push_exp("pc_x0", 1, 2, 1, 1, 0);

    do_reset();
    commit(0, P0, P0 + 4);
    drive(1, 1, P0 + 4, P0 + 8, 5'd0, 32'd5, 32'd0, 4'd0, 4'd0);
    push_exp("x0", 1, 3, 1, 1, 0);

    do_reset();
    drive(1, 0, P0, P0 + 4, 5'd0, 32'd7, 32'd0, 4'd0, 4'd0);
    push_exp("first_x0", 1, 3, 0, 0, 0);

    do_reset();
    commit(0, P0, P0 + 4);
    drive(1, 1, P0 + 4, P0 + 8, 5'd1, 32'd0, P0 + 2, 4'b1111, 4'b0000);
    push_exp("mem_rd", 1, 4, 1, 1, 0);

    do_reset();
    commit(0, P0, P0 + 4);
    drive(1, 1, P0 + 4, P0 + 8, 5'd1, 32'd0, P0 + 2, 4'b0000, 4'b0011);
    push_exp("mem_wr_ok", 0, 0, 0, 2, 0);

    do_reset();
    commit(0, P0, P0 + 4);
    drive(1, 1, P0 + 4, P0 + 8, 5'd1, 32'd0, P0, 4'b0001, 4'b0001);
    push_exp("mem_rw", 1, 4, 1, 1, 0);

    do_reset();
    commit(0, P0, P0 + 4);
    for (int k = 1; k <= 8; k++) begin
      idle();
      if (k == 7) push_exp("wd_7", 0, 0, 0, 1, 0);
      if (k == 8) push_exp("deadlock", 1, 5, 1, 1, 0);
    end

    do_reset();
    commit(0, P0, P0 + 4);
    for (int k = 1; k <= 7; k++) idle();
    commit(1, P0 + 4, P0 + 8); push_exp("wd_save", 0, 0, 0, 2, 0);
    idle();                    push_exp("wd_after", 0, 0, 0, 2, 0);

    do_reset();
    commit(0, P0 + 12, P0 + 16);
    commit(1, P0 + 16, P0 + 16); push_exp("halt", 0, 0, 0, 2, 1);
    commit(2, P0 + 16, P0 + 20); push_exp("halt_ignore", 0, 0, 0, 2, 1);
    for (int i = 0; i < 10; i++) idle();
    push_exp("halt_no_wd", 0, 0, 0, 2, 1);

    do_reset();

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) chk("drain", "pending", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
